// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - pipeline request/response and memory port bundle for lsu_mem_ctrl
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    // slave: the load/store unit itself
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output stall, rsp_valid, rsp_rdata, misalign,
        output mem_addr, mem_wdata, mem_be, mem_we, mem_re
    );

    // master: the pipeline plus the data memory
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  stall, rsp_valid, rsp_rdata, misalign,
        input  mem_addr, mem_wdata, mem_be, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - single-outstanding load/store initiator with lane steering and wait states
// Misaligned/illegal requests complete in one cycle without touching memory.
module lsu_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic          Clk,
    input  logic          Reset,
    lsu_mem_ctrl_if.slave bus
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic        op_write, op_write_nxt;
    logic [1:0]  op_size, op_size_nxt;
    logic        op_unsigned, op_unsigned_nxt;
    logic [1:0]  op_off, op_off_nxt;

    logic        rsp_valid_nxt;
    logic [31:0] rsp_rdata_nxt;
    logic        misalign_nxt;
    logic [31:0] mem_addr_nxt;
    logic [31:0] mem_wdata_nxt;
    logic [3:0]  mem_be_nxt;
    logic        mem_we_nxt;
    logic        mem_re_nxt;

    logic        req_bad;
    logic [3:0]  be_steer;
    logic [31:0] wdata_steer;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;

    assign bus.stall = bus.req_valid && (state != DONE);

    always_comb begin
        req_bad     = 1'b0;
        be_steer    = 4'b1111;
        wdata_steer = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be_steer    = 4'b0001 << bus.req_addr[1:0];
                wdata_steer = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                req_bad     = bus.req_addr[0];
                be_steer    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_steer = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   req_bad = (bus.req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    // Extraction works from the captured offset/size, so later req_* changes cannot corrupt it.
    always_comb begin
        lane_b = bus.mem_rdata[{op_off, 3'b000} +: 8];
        lane_h = bus.mem_rdata[{op_off[1], 4'b0000} +: 16];
        case (op_size)
            2'b00:   load_val = {{24{lane_b[7] & ~op_unsigned}}, lane_b};
            2'b01:   load_val = {{16{lane_h[15] & ~op_unsigned}}, lane_h};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        op_write_nxt    = op_write;
        op_size_nxt     = op_size;
        op_unsigned_nxt = op_unsigned;
        op_off_nxt      = op_off;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = bus.rsp_rdata;
        misalign_nxt    = bus.misalign;
        mem_addr_nxt    = bus.mem_addr;
        mem_wdata_nxt   = bus.mem_wdata;
        mem_be_nxt      = bus.mem_be;
        mem_we_nxt      = 1'b0;
        mem_re_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_bad) begin
                        state_nxt     = DONE;
                        rsp_valid_nxt = 1'b1;
                        misalign_nxt  = 1'b1;
                        rsp_rdata_nxt = 32'h0;
                    end else begin
                        state_nxt       = ACCESS;
                        cnt_nxt         = 4'd0;
                        op_write_nxt    = bus.req_write;
                        op_size_nxt     = bus.req_size;
                        op_unsigned_nxt = bus.req_unsigned;
                        op_off_nxt      = bus.req_addr[1:0];
                        mem_addr_nxt    = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_nxt   = wdata_steer;
                        mem_be_nxt      = be_steer;
                        mem_re_nxt      = !bus.req_write;
                        mem_we_nxt      = bus.req_write && (WAIT_LAST == 4'd0);
                    end
                end
            end
            ACCESS: begin
                if (cnt == WAIT_LAST) begin
                    state_nxt     = DONE;
                    rsp_valid_nxt = 1'b1;
                    misalign_nxt  = 1'b0;
                    rsp_rdata_nxt = op_write ? 32'h0 : load_val;
                end else begin
                    cnt_nxt    = cnt + 4'd1;
                    mem_re_nxt = !op_write;
                    // Strobes are registered, so the single write is armed one edge ahead.
                    mem_we_nxt = op_write && ((cnt + 4'd1) == WAIT_LAST);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            op_write      <= 1'b0;
            op_size       <= 2'b00;
            op_unsigned   <= 1'b0;
            op_off        <= 2'b00;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.misalign  <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            bus.mem_be    <= 4'h0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            op_write      <= op_write_nxt;
            op_size       <= op_size_nxt;
            op_unsigned   <= op_unsigned_nxt;
            op_off        <= op_off_nxt;
            bus.rsp_valid <= rsp_valid_nxt;
            bus.rsp_rdata <= rsp_rdata_nxt;
            bus.misalign  <= misalign_nxt;
            bus.mem_addr  <= mem_addr_nxt;
            bus.mem_wdata <= mem_wdata_nxt;
            bus.mem_be    <= mem_be_nxt;
            bus.mem_we    <= mem_we_nxt;
            bus.mem_re    <= mem_re_nxt;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl against a byte-level memory model
module tb_lsu_mem_ctrl;
    localparam int W = 3;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    lsu_mem_ctrl_if bus();
    lsu_mem_ctrl #(.WAIT_CYCLES(W)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } wr_t;

    rsp_t rq[$];
    wr_t  wq[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [31:0] mem[16];
    logic [31:0] seed[16];
    logic [31:0] ref_mem[16];
    logic        mem_init = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];
    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= seed[i];
        end else if (bus.mem_we) begin
            for (int k = 0; k < 4; k++)
                if (bus.mem_be[k]) mem[bus.mem_addr[5:2]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] get_byte(input int a);
        logic [31:0] wv;
        wv = ref_mem[a / 4];
        return 8'(wv >> (8 * (a % 4)));
    endfunction

    task automatic set_byte(input int a, input logic [7:0] b);
        int sh;
        sh = 8 * (a % 4);
        ref_mem[a / 4] = (ref_mem[a / 4] & ~(32'hFF << sh)) | ({24'h0, b} << sh);
    endtask

    // Monitor: every response and every write strobe is matched against the scoreboard queues.
    initial begin
        rsp_t r;
        wr_t  w;
        forever begin
            @(negedge Clk);
            #1;
            if (bus.rsp_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'd1, 32'd0);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, r.rdata);
                    chk("misalign", {31'b0, bus.misalign}, {31'b0, r.mis});
                    chk("rsp_cycle", cyc, r.cyc);
                end
            end
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_mem_we", 32'd1, 32'd0);
                end else begin
                    w = wq.pop_front();
                    chk("mem_addr", bus.mem_addr, w.addr);
                    chk("mem_be", {28'b0, bus.mem_be}, {28'b0, w.be});
                    chk("mem_wdata", bus.mem_wdata, w.wdata);
                    chk("mem_we_cycle", cyc, w.cyc);
                end
            end
        end
    end

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int n, lat, issue, n_re, n_we, a;
        bit mis, got;
        logic [31:0] val;
        logic [3:0] be_e;
        rsp_t r;
        wr_t w;
        mis = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lat = mis ? 1 : W + 2;
        issue = cyc;
        val = 32'h0;
        be_e = 4'h0;
        if (!mis) begin
            if (wr) begin
                for (int k = 0; k < n; k++) begin
                    a = int'(addr) + k;
                    be_e[a % 4] = 1'b1;
                    set_byte(a, 8'(wd >> (8 * k)));
                end
                w.addr  = addr & 32'hFFFF_FFFC;
                w.be    = be_e;
                w.wdata = (sz == 2'd0) ? (wd & 32'hFF) * 32'h0101_0101 :
                          (sz == 2'd1) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
                w.cyc   = issue + W + 1;
                wq.push_back(w);
            end else begin
                for (int k = 0; k < n; k++) val = val | ({24'h0, get_byte(int'(addr) + k)} << (8 * k));
                if (!uns && n < 4 && ((val >> (8 * n - 1)) & 32'h1) == 32'h1)
                    val = val | (32'hFFFF_FFFF << (8 * n));
            end
        end
        r.rdata = val;
        r.mis = mis;
        r.cyc = issue + lat;
        rq.push_back(r);

        bus.req_write = wr;
        bus.req_size = sz;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        n_re = 0;
        n_we = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            chk("stall", {31'b0, bus.stall}, (i != lat) ? 32'd1 : 32'd0);
            n_re += int'(bus.mem_re);
            n_we += int'(bus.mem_we);
            if (bus.rsp_valid) got = 1'b1;
            else @(negedge Clk);
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
        chk("mem_re_cycles", n_re, (!mis && !wr) ? W + 1 : 0);
        chk("mem_we_cycles", n_we, (!mis && wr) ? 1 : 0);
        @(negedge Clk);
    endtask

    task automatic reset_mid_store(input logic [31:0] addr, input logic [31:0] wd);
        bus.req_write = 1'b1;
        bus.req_size = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_mem_re", {31'b0, bus.mem_re}, 32'd0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_misalign", {31'b0, bus.misalign}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) seed[i] = $urandom;
        seed[0] = 32'h8001_FF7F;
        for (int i = 0; i < 16; i++) ref_mem[i] = seed[i];
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        mem_init = 1'b1;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("reset_mem_re", {31'b0, bus.mem_re}, 32'd0);
        chk("reset_mem_be", {28'b0, bus.mem_be}, 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_stall", {31'b0, bus.stall}, 32'd0);
        @(negedge Clk);
        mem_init = 1'b0;
        Reset = 1'b0;
        @(negedge Clk);

        do_req(1'b0, 2'd0, 1'b0, 32'h1, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h3, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_req(1'b1, 2'd0, 1'b0, 32'h6, 32'h0000_00A5);
        do_req(1'b1, 2'd1, 1'b0, 32'h2, 32'h0000_1234);
        do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        do_req(1'b1, 2'd1, 1'b0, 32'h5, 32'hFFFF_FFFF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        for (int t = 0; t < 60; t++)
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 63)), $urandom);

        reset_mid_store(32'h20, 32'hCAFE_F00D);
        do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h1357_9BDF);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

        for (int t = 0; t < 20; t++)
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 63)), $urandom);

        repeat (4) @(negedge Clk);
        chk("rsp_queue_drained", rq.size(), 32'd0);
        chk("wr_queue_drained", wq.size(), 32'd0);
        for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
CPU-side load/store initiator for the word-addressed data memory; sits in the MEM stage between the pipeline and the memory port.
Accepts one load or store request at a time, steers byte/halfword lanes, generates byte enables, and runs a parameterised wait-state access sequence.
For loads it extracts the addressed lane and sign- or zero-extends the result.
Detects misaligned and illegal-size accesses without touching memory, and stalls the pipeline until each request completes.

Parameters:
WAIT_CYCLES, 1, extra memory wait states per access (0..15); an access occupies WAIT_CYCLES+1 cycles.

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present; pipeline holds all req_* stable while stall=1
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  1=zero-extend load (lbu/lhu), 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  combinational: req_valid && state!=DONE
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load result; 0 for stores/errors
misalign  out  1  error flag, valid with rsp_valid
mem_addr  out  32  word-aligned address {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables, bit i = byte lane i
mem_we  out  1  write strobe (memory writes on Clk rising edge)
mem_re  out  1  read enable
mem_rdata  in  32  combinational read data from memory

Behaviour:
- States: IDLE, ACCESS, DONE. A 4-bit wait counter is used in ACCESS.
- Reset (async): state=IDLE, counter=0. All registered outputs are 0: rsp_valid, rsp_rdata, misalign, mem_addr, mem_wdata, mem_be, mem_we, mem_re.
- IDLE with req_valid=1, legal and aligned request:
  - Register mem_addr, mem_wdata and mem_be.
  - Go to ACCESS with counter=0.
- IDLE with req_valid=1, misaligned or illegal request:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. Illegal means size=11.
  - Go directly to DONE with misalign=1 and rsp_rdata=0.
  - No mem_re or mem_we is issued.
- IDLE with req_valid=0: stay in IDLE.
- Lane steering:
  - Byte: mem_be=4'b0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - Half: mem_be=addr[1]?1100:0011; mem_wdata={2{wdata[15:0]}}.
  - Word: mem_be=1111; mem_wdata=wdata.
- ACCESS:
  - mem_re=1 for every cycle of a load.
  - mem_we=1 only on the final ACCESS cycle (counter==WAIT_CYCLES) of a store, so exactly one write strobe per store.
  - The counter increments each cycle.
  - On the final cycle, go to DONE. For a load, capture the extracted and extended mem_rdata into rsp_rdata.
- Load extraction:
  - Byte: lane=mem_rdata[8*addr[1:0]+:8]; bit 7 of the lane is the sign.
  - Half: lane=mem_rdata[16*addr[1]+:16]; bit 15 of the lane is the sign.
  - Sign-extend unless req_unsigned=1, in which case zero-extend. Word loads pass through unchanged.
- DONE:
  - rsp_valid=1 for exactly one cycle.
  - mem_we and mem_re are 0.
  - Return to IDLE unconditionally.
  - The pipeline advances on this edge; a new request is accepted no earlier than the following cycle (one-cycle bubble).
- rsp_rdata and misalign hold their value until the next DONE. Stores set rsp_rdata=0.
- Latency, with request first seen in IDLE at cycle 0:
  - Aligned access: rsp_valid in cycle WAIT_CYCLES+2.
  - Misaligned access: rsp_valid in cycle 1.
- Changes to req_* while in ACCESS violate the protocol; captured values are used and later changes are ignored.
- Reset asserted mid-ACCESS: mem_we drops immediately, the pending store is abandoned (no partial write), and no rsp_valid is produced.
- req_valid dropping mid-access: the access still completes; rsp_valid still pulses.

Test Plan:
1. WAIT_CYCLES=1, store word 0xDEADBEEF @0x10 → mem_addr=0x10, be=1111, mem_we high exactly 1 cycle (cycle 2), rsp_valid cycle 3, stall high cycles 0-2.
2. Memory word=0x8001FF7F, load byte signed @0x1 → rsp_rdata=0xFFFFFFFF. Same @0x0 → 0x0000007F. @0x3 unsigned → 0x00000080.
3. Memory=0x8001FF7F, load half signed @0x2 → 0xFFFF8001. @0x0 unsigned → 0x0000FF7F.
4. Store byte 0xA5 @0x6 → be=0100, mem_wdata=0xA5A5A5A5. Store half 0x1234 @0x2 → be=1100, mem_wdata=0x12341234.
5. Load word @0x2 and size=11 @0x0 → misalign=1, rsp_valid in cycle 1, rsp_rdata=0, mem_re/mem_we never asserted.
6. WAIT_CYCLES=3, store with Reset pulsed in 2nd ACCESS cycle → outputs 0 immediately, no mem_we ever high, no rsp_valid, next request completes normally in 5 cycles.
